pc_target_unit: RTL and testbench

Registered next-PC target generator for the MIPS datapath. It is the parametrised successor to the fixed 26→28-bit jump shifter. It computes sequential, jump, branch and jump-register targets in one place and holds the result in a valid/ready output stage. After any taken control transfer it drives a counted flush window. It sits between decode and the PC register/fetch stage.

---
 rtl/pc_target_pkg.sv | 16 +
 rtl/pc_target_calc.sv | 54 +++++
 rtl/pc_target_unit.sv | 101 ++++++++++
 tb/tb_pc_target_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_target_pkg.sv
// Shared encodings for the next-PC target unit: request modes and flush FSM states.
package pc_target_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SEQ    = 2'd0;
  localparam mode_t MODE_JUMP   = 2'd1;
  localparam mode_t MODE_BRANCH = 2'd2;
  localparam mode_t MODE_JR     = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection for sequential, jump, branch and jump-register flow.
module pc_target_calc
  import pc_target_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 26,
  parameter int unsigned IMM_W  = 16
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [IDX_W-1:0]  instr_index,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] calc_target,
  output logic              calc_redirect,
  output logic              calc_misaligned
);

  localparam int unsigned EXT_W = ADDR_W - IMM_W;

  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] branch_off;

  assign imm_sext   = {{EXT_W{imm[IMM_W-1]}}, imm};
  assign branch_off = {imm_sext[ADDR_W-3:0], 2'b00};

  always_comb begin
    calc_target     = pc_plus4;
    calc_redirect   = 1'b0;
    calc_misaligned = 1'b0;
    case (mode_t'(mode))
      MODE_SEQ: ;
      MODE_JUMP: begin
        calc_target   = {pc_plus4[ADDR_W-1:IDX_W+2], instr_index, 2'b00};
        calc_redirect = 1'b1;
      end
      MODE_BRANCH: begin
        if (branch_taken) begin
          calc_target   = pc_plus4 + branch_off;
          calc_redirect = 1'b1;
        end
      end
      MODE_JR: begin
        // Target passes through unmodified; alignment is only reported.
        calc_target     = reg_target;
        calc_redirect   = 1'b1;
        calc_misaligned = |reg_target[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_target_unit.sv
// Registered next-PC target stage with valid/ready handshake and a counted flush window after redirects.
module pc_target_unit
  import pc_target_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned IDX_W        = 26,
  parameter int unsigned IMM_W        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [IDX_W-1:0]  instr_index,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              branch_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target,
  output logic              redirect,
  output logic              misaligned,
  output logic              flush
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [ADDR_W-1:0] calc_target;
  logic              calc_redirect;
  logic              calc_misaligned;
  logic              accept;
  logic              out_hs;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  pc_target_calc #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .IMM_W  (IMM_W)
  ) u_calc (
    .mode            (mode),
    .pc_plus4        (pc_plus4),
    .instr_index     (instr_index),
    .imm             (imm),
    .reg_target      (reg_target),
    .branch_taken    (branch_taken),
    .calc_target     (calc_target),
    .calc_redirect   (calc_redirect),
    .calc_misaligned (calc_misaligned)
  );

  // A held redirect blocks same-cycle acceptance so no wrong-path request slips in.
  assign in_ready = (state == ST_IDLE) && (!out_valid || (out_ready && !redirect));
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      target     <= '0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      flush      <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        target     <= calc_target;
        redirect   <= calc_redirect;
        misaligned <= calc_misaligned;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (out_hs && redirect && (FLUSH_CYCLES > 0)) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
            flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed self-checking bench for pc_target_unit with FLUSH_CYCLES=2.
module tb_pc_target_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] pc_plus4;
  logic [25:0] instr_index;
  logic [15:0] imm;
  logic [31:0] reg_target;
  logic        branch_taken;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic        redirect;
  logic        misaligned;
  logic        flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_target_unit #(
    .ADDR_W       (32),
    .IDX_W        (26),
    .IMM_W        (16),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .pc_plus4     (pc_plus4),
    .instr_index  (instr_index),
    .imm          (imm),
    .reg_target   (reg_target),
    .branch_taken (branch_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .target       (target),
    .redirect     (redirect),
    .misaligned   (misaligned),
    .flush        (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Wait (at negedges) until in_ready, bounded.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Present one request, wait for acceptance, and return at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [1:0] m, input logic [31:0] pc,
                      input logic [25:0] idx, input logic [15:0] im,
                      input logic [31:0] rt, input logic tk);
    mode = m; pc_plus4 = pc; instr_index = idx; imm = im; reg_target = rt; branch_taken = tk;
    in_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 2'd0; pc_plus4 = '0; instr_index = '0; imm = '0; reg_target = '0; branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // JUMP with backpressure
    send("jump", 2'd1, 32'h4000_1000, 26'h000_0100, 16'h0, 32'h0, 1'b0);
    check("jump_valid", 32'(out_valid), 32'd1);
    check("jump_target", target, 32'h4000_0400);
    check("jump_redirect", 32'(redirect), 32'd1);
    check("jump_misaligned", 32'(misaligned), 32'd0);
    mode = 2'd0; pc_plus4 = 32'h0000_1234; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("hold_target", target, 32'h4000_0400);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("redir_no_same_accept", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("flush1", 32'(flush), 32'd1);
    check("flush1_in_ready", 32'(in_ready), 32'd0);
    check("flush1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("flush2", 32'(flush), 32'd1);
    check("flush2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("flush_end", 32'(flush), 32'd0);
    check("flush_end_in_ready", 32'(in_ready), 32'd1);

    // BRANCH taken, backward
    send("br_t", 2'd2, 32'h0040_0010, 26'h0, 16'hFFFC, 32'h0, 1'b1);
    check("br_t_target", target, 32'h0040_0000);
    check("br_t_redirect", 32'(redirect), 32'd1);
    @(negedge clk);
    check("br_t_flush", 32'(flush), 32'd1);

    // BRANCH not taken
    send("br_nt", 2'd2, 32'h0040_0010, 26'h0, 16'hFFFC, 32'h0, 1'b0);
    check("br_nt_target", target, 32'h0040_0010);
    check("br_nt_redirect", 32'(redirect), 32'd0);
    check("br_nt_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("br_nt_no_flush", 32'(flush), 32'd0);

    // Wrap-around branch
    send("wrap", 2'd2, 32'hFFFF_FFFC, 26'h0, 16'h0002, 32'h0, 1'b1);
    check("wrap_target", target, 32'h0000_0004);
    check("wrap_redirect", 32'(redirect), 32'd1);

    // JR misaligned
    send("jr", 2'd3, 32'h0000_0100, 26'h0, 16'h0, 32'h0040_0006, 1'b0);
    check("jr_target", target, 32'h0040_0006);
    check("jr_misaligned", 32'(misaligned), 32'd1);
    check("jr_redirect", 32'(redirect), 32'd1);

    // Back-to-back SEQ
    @(negedge clk);
    wait_ready("seq_start");
    mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_plus4 = 32'h0000_1000 + 32'(4 * i);
      check("seq_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("seq_target", target, 32'h0000_1000 + 32'(4 * i));
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_redirect", 32'(redirect), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("seq_drain", 32'(out_valid), 32'd0);

    // Reset in first FLUSH cycle
    send("jrst", 2'd1, 32'h4000_1000, 26'h000_0100, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("jrst_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("jrst_flush_clr", 32'(flush), 32'd0);
    check("jrst_valid_clr", 32'(out_valid), 32'd0);
    check("jrst_in_ready", 32'(in_ready), 32'd1);
    check("jrst_target", target, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("jrst_after_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
